video_stream_out: RTL and testbench

Parametrised stream-to-clocked-video output stage: accepts pixels on a valid/ready stream with start-of-packet marking and drives a raster with programmable active, porch and sync widths. It is the generalised successor to the fixed 24-bit VGA clocked-video output in the Qsys system. It adds configurable channel count and width, sync polarity, and an input FIFO of configurable depth. It also adds automatic frame re-lock after underflow or misaligned input. It sits between the frame-buffer reader and the VGA/HDMI pin drivers, in the video clock domain.

---
 rtl/video_out_pkg.sv | 16 +
 rtl/stream_fifo.sv | 66 ++++++
 rtl/video_stream_out.sv | 226 ++++++++++++++++++++++
 tb/tb_video_stream_out.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_out_pkg.sv
// Shared types and helpers for the stream-to-clocked-video output stage.
// Holds the sequencer state encoding and the raster-total arithmetic.
package video_out_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SYNC_WAIT = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    // Cycles per line or lines per frame from the four timing fields.
    function automatic int raster_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous show-ahead FIFO with flush; head entry is visible on pop_data
// whenever empty is low. Written entries become readable on the following cycle.
module stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == FULL_COUNT);
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign do_push_s = push & ~full & ~flush;
    assign do_pop_s  = pop & ~empty & ~flush;
    assign pop_data  = mem_r[rd_ptr_r];

    // Storage array; not reset, contents only matter once counted in.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/video_stream_out.sv
// Stream-to-clocked-video output: buffers {sop, pixel} in a FIFO and drives a
// programmable raster, locking to start-of-frame and re-locking after faults.
module video_stream_out
    import video_out_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int BITS_PER_CH = 8,
    parameter int CHANNELS    = 3,
    parameter int SYNC_POL    = 0,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                            clk_clk,
    input  logic                            reset_reset_n,
    input  logic                            enable,
    input  logic [BITS_PER_CH*CHANNELS-1:0] in_data,
    input  logic                            in_sop,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [BITS_PER_CH*CHANNELS-1:0] vid_data,
    output logic                            vid_datavalid,
    output logic                            vid_h_sync,
    output logic                            vid_v_sync,
    output logic                            vid_h,
    output logic                            vid_v,
    output logic                            underflow,
    input  logic                            underflow_clear
);

    localparam int DW      = BITS_PER_CH * CHANNELS;
    localparam int H_TOTAL = raster_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = raster_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_ACT_C    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_FIN = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_C    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_FIN = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic          SYNC_ACT   = (SYNC_POL != 0);

    state_t          state_r;
    state_t          state_s;
    logic [HW-1:0]   h_cnt_r;
    logic [VW-1:0]   v_cnt_r;

    logic [DW:0]     fifo_head_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic            fifo_flush_s;
    logic            fifo_push_s;
    logic            fifo_pop_s;
    logic            head_sop_s;
    logic [DW-1:0]   head_data_s;

    logic            active_s;
    logic            origin_s;
    logic            h_sync_s;
    logic            v_sync_s;
    logic            show_s;
    logic            underflow_set_s;

    logic [DW-1:0]   vid_data_r;
    logic            vid_datavalid_r;
    logic            vid_h_sync_r;
    logic            vid_v_sync_r;
    logic            vid_h_r;
    logic            vid_v_r;
    logic            underflow_r;

    assign head_sop_s   = fifo_head_s[DW];
    assign head_data_s  = fifo_head_s[DW-1:0];
    assign active_s     = (h_cnt_r < H_ACT_C) && (v_cnt_r < V_ACT_C);
    assign origin_s     = (h_cnt_r == {HW{1'b0}}) && (v_cnt_r == {VW{1'b0}});
    assign h_sync_s     = (h_cnt_r >= H_SYNC_BEG) && (h_cnt_r < H_SYNC_FIN);
    assign v_sync_s     = (v_cnt_r >= V_SYNC_BEG) && (v_cnt_r < V_SYNC_FIN);

    assign in_ready     = enable & (state_r != ST_IDLE) & ~fifo_full_s;
    assign fifo_push_s  = in_valid & in_ready;
    assign fifo_flush_s = ~enable | (state_r == ST_IDLE);

    stream_fifo #(
        .WIDTH (DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .flush     (fifo_flush_s),
        .push      (fifo_push_s),
        .push_data ({in_sop, in_data}),
        .pop       (fifo_pop_s),
        .pop_data  (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Sequencer: frame lock, per-pixel pop decisions and fault re-lock.
    always_comb begin
        state_s         = state_r;
        fifo_pop_s      = 1'b0;
        show_s          = 1'b0;
        underflow_set_s = 1'b0;
        if (!enable) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_SYNC_WAIT;
                end
                ST_SYNC_WAIT: begin
                    if (fifo_empty_s) begin
                        state_s = ST_SYNC_WAIT;
                    end else if (!head_sop_s) begin
                        fifo_pop_s = 1'b1;
                    end else if (origin_s) begin
                        fifo_pop_s = 1'b1;
                        show_s     = 1'b1;
                        state_s    = ST_RUN;
                    end else begin
                        state_s = ST_SYNC_WAIT;
                    end
                end
                ST_RUN: begin
                    if (!active_s) begin
                        state_s = ST_RUN;
                    end else if (fifo_empty_s) begin
                        underflow_set_s = 1'b1;
                        state_s         = ST_SYNC_WAIT;
                    end else if (head_sop_s && !origin_s) begin
                        // Leave the early sop in place so it starts the next frame.
                        state_s = ST_SYNC_WAIT;
                    end else begin
                        fifo_pop_s = 1'b1;
                        show_s     = 1'b1;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Raster counters; held at the origin while idle or disabled.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            h_cnt_r <= {HW{1'b0}};
            v_cnt_r <= {VW{1'b0}};
        end else if (!enable || (state_r == ST_IDLE)) begin
            h_cnt_r <= {HW{1'b0}};
            v_cnt_r <= {VW{1'b0}};
        end else if (h_cnt_r == H_LAST) begin
            h_cnt_r <= {HW{1'b0}};
            v_cnt_r <= (v_cnt_r == V_LAST) ? {VW{1'b0}} : v_cnt_r + 1'b1;
        end else begin
            h_cnt_r <= h_cnt_r + 1'b1;
        end
    end

    // Video output registers, one cycle behind the counters.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            vid_data_r      <= {DW{1'b0}};
            vid_datavalid_r <= 1'b0;
            vid_h_sync_r    <= ~SYNC_ACT;
            vid_v_sync_r    <= ~SYNC_ACT;
            vid_h_r         <= 1'b0;
            vid_v_r         <= 1'b0;
        end else if (!enable) begin
            vid_data_r      <= {DW{1'b0}};
            vid_datavalid_r <= 1'b0;
            vid_h_sync_r    <= ~SYNC_ACT;
            vid_v_sync_r    <= ~SYNC_ACT;
            vid_h_r         <= 1'b0;
            vid_v_r         <= 1'b0;
        end else begin
            vid_data_r      <= show_s ? head_data_s : {DW{1'b0}};
            vid_datavalid_r <= show_s;
            vid_h_sync_r    <= h_sync_s ? SYNC_ACT : ~SYNC_ACT;
            vid_v_sync_r    <= v_sync_s ? SYNC_ACT : ~SYNC_ACT;
            vid_h_r         <= (h_cnt_r >= H_ACT_C);
            vid_v_r         <= (v_cnt_r >= V_ACT_C);
        end
    end

    // Sticky underflow flag; a new underflow outranks a simultaneous clear.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            underflow_r <= 1'b0;
        end else if (underflow_set_s) begin
            underflow_r <= 1'b1;
        end else if (underflow_clear) begin
            underflow_r <= 1'b0;
        end else begin
            underflow_r <= underflow_r;
        end
    end

    assign vid_data      = vid_data_r;
    assign vid_datavalid = vid_datavalid_r;
    assign vid_h_sync    = vid_h_sync_r;
    assign vid_v_sync    = vid_v_sync_r;
    assign vid_h         = vid_h_r;
    assign vid_v         = vid_v_r;
    assign underflow     = underflow_r;

endmodule

// File: tb/tb_video_stream_out.sv
// Scoreboard bench for video_stream_out on an 8x6 raster: a position model
// predicts blanking/sync per cycle and a queue holds the pixels expected out.
module tb_video_stream_out;

    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int DW = 24;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_sop = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] vid_data;
    logic          vid_datavalid, vid_h_sync, vid_v_sync, vid_h, vid_v, underflow;
    logic          underflow_clear = 1'b0;

    int   passed = 0;
    int   total = 0;
    int   dv_count = 0;
    exp_t expq[$];

    int   mpos;
    logic midle, e_h, e_v, e_hs, e_vs, e_act, e_start;

    video_stream_out #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .BITS_PER_CH(8), .CHANNELS(3), .SYNC_POL(0), .FIFO_DEPTH(16)
    ) dut (
        .clk_clk(clk), .reset_reset_n(rst_n), .enable(enable),
        .in_data(in_data), .in_sop(in_sop), .in_valid(in_valid), .in_ready(in_ready),
        .vid_data(vid_data), .vid_datavalid(vid_datavalid),
        .vid_h_sync(vid_h_sync), .vid_v_sync(vid_v_sync),
        .vid_h(vid_h), .vid_v(vid_v),
        .underflow(underflow), .underflow_clear(underflow_clear)
    );

    always #5 clk = ~clk;

    function automatic logic in_hsync(input int p);
        return ((p % HT) >= HA + HF) && ((p % HT) < HA + HF + HS);
    endfunction

    function automatic logic in_vsync(input int p);
        return ((p / HT) >= VA + VF) && ((p / HT) < VA + VF + VS);
    endfunction

    // Reference raster position: restarts at 0 after a disabled/reset spell,
    // and the flags for position p appear on the ports one cycle later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || !enable) begin
            mpos <= 0; midle <= 1'b1;
            e_h <= 1'b0; e_v <= 1'b0; e_hs <= 1'b1; e_vs <= 1'b1;
            e_act <= 1'b0; e_start <= 1'b0;
        end else begin
            e_h     <= (mpos % HT) >= HA;
            e_v     <= (mpos / HT) >= VA;
            e_hs    <= !in_hsync(mpos);
            e_vs    <= !in_vsync(mpos);
            e_act   <= !midle && ((mpos % HT) < HA) && ((mpos / HT) < VA);
            e_start <= !midle && (mpos == 0);
            mpos    <= midle ? 0 : (mpos + 1) % FT;
            midle   <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) $display("FAIL %s: got %0h, expected %0h", name, act, req);
        else passed++;
    endtask

    task automatic fail_msg(input string name, input string what);
        total++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Monitor: per-cycle raster flags and popping the pixel scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("vid_h", vid_h, e_h);
                chk("vid_v", vid_v, e_v);
                chk("vid_h_sync", vid_h_sync, e_hs);
                chk("vid_v_sync", vid_v_sync, e_vs);
                if (vid_datavalid) begin
                    dv_count++;
                    chk("dv_in_active_region", e_act, 1);
                    if (expq.size() == 0) begin
                        fail_msg("unexpected_pixel", $sformatf("got data %0h, expected no pixel", vid_data));
                    end else begin
                        e = expq.pop_front();
                        chk("pixel_data", vid_data, e.data);
                        if (e.sop) chk("sop_at_frame_start", e_start, 1);
                    end
                end else begin
                    chk("blank_data_zero", vid_data, 0);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic send(input logic [DW-1:0] d, input logic s, input bit expected);
        int g = 0;
        in_data = d; in_sop = s; in_valid = 1'b1;
        while (!in_ready && g < 500) begin cyc(1); g++; end
        if (!in_ready) begin
            fail_msg("push_timeout", "in_ready stayed 0, expected 1 within 500 cycles");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (expected) expq.push_back('{data: d, sop: s});
        #1;
        cyc(1);
    endtask

    task automatic send_frame(input int n, input bit ramp);
        for (int i = 0; i < n; i++) begin
            send(ramp ? DW'(i) : DW'($urandom), (i == 0), 1'b1);
        end
        in_valid = 1'b0; in_sop = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int g = 0;
        while (expq.size() != 0 && g < limit) begin cyc(1); g++; end
        if (expq.size() != 0) begin
            fail_msg(name, $sformatf("%0d pixels still pending, expected 0", expq.size()));
            expq.delete();
        end
    endtask

    task automatic wait_dv(input string name, input int target, input int limit);
        int g = 0;
        while (dv_count < target && g < limit) begin cyc(1); g++; end
        if (dv_count < target) fail_msg(name, $sformatf("dv count %0d, expected %0d", dv_count, target));
    endtask

    task automatic restart();
        enable = 1'b0;
        cyc(3);
        underflow_clear = 1'b1;
        cyc(1);
        underflow_clear = 1'b0;
        chk("underflow_cleared", underflow, 0);
        chk("disabled_dv", vid_datavalid, 0);
        enable = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_vid_data"}, vid_data, 0);
        chk({tag, "_datavalid"}, vid_datavalid, 0);
        chk({tag, "_vid_h"}, vid_h, 0);
        chk({tag, "_vid_v"}, vid_v, 0);
        chk({tag, "_h_sync"}, vid_h_sync, 1);
        chk({tag, "_v_sync"}, vid_v_sync, 1);
        chk({tag, "_underflow"}, underflow, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
    endtask

    initial begin
        int d0, hs_low, vs_low, dv_seen;

        #12;
        check_reset_values("reset");
        @(negedge clk); rst_n = 1'b1; #1;
        chk("in_ready_first_cycle", in_ready, 0);
        cyc(1);
        chk("in_ready_second_cycle", in_ready, 1);

        // Free-run with no input.
        cyc(10);
        hs_low = 0; vs_low = 0; dv_seen = 0;
        for (int i = 0; i < 2 * FT; i++) begin
            cyc(1);
            hs_low += int'(!vid_h_sync);
            vs_low += int'(!vid_v_sync);
            dv_seen += int'(vid_datavalid);
        end
        chk("freerun_hsync_low_cycles", hs_low, 24);
        chk("freerun_vsync_low_cycles", vs_low, 16);
        chk("freerun_datavalid_cycles", dv_seen, 0);
        chk("freerun_underflow", underflow, 0);

        // Two back-to-back ramp frames.
        restart();
        d0 = dv_count;
        send_frame(12, 1'b1);
        send_frame(12, 1'b1);
        wait_drain("ramp_drain", 600);
        chk("ramp_dv_count", dv_count - d0, 24);
        chk("ramp_underflow", underflow, 0);

        // Short frame: underflow at the 6th slot, clear collides with the set.
        restart();
        d0 = dv_count;
        send_frame(5, 1'b0);
        wait_dv("short_frame_dv", d0 + 5, 400);
        chk("underflow_before_slot6", underflow, 0);
        underflow_clear = 1'b1;
        cyc(1);
        chk("underflow_set_wins", underflow, 1);
        chk("slot6_blank", vid_datavalid, 0);
        underflow_clear = 1'b0;
        cyc(1);
        chk("underflow_sticky", underflow, 1);
        underflow_clear = 1'b1;
        cyc(1);
        underflow_clear = 1'b0;
        chk("underflow_clear_alone", underflow, 0);
        d0 = dv_count;
        send_frame(12, 1'b0);
        wait_drain("relock_drain", 400);
        chk("relock_dv_count", dv_count - d0, 12);

        // Three pixels without sop ahead of a real frame.
        restart();
        d0 = dv_count;
        for (int i = 0; i < 3; i++) send(DW'($urandom), 1'b0, 1'b0);
        send_frame(12, 1'b0);
        wait_drain("misaligned_drain", 400);
        chk("misaligned_dv_count", dv_count - d0, 12);

        // Enable drops mid-line while running.
        restart();
        d0 = dv_count;
        send_frame(12, 1'b0);
        wait_dv("run_before_disable", d0 + 2, 400);
        enable = 1'b0;
        cyc(1);
        chk("disable_dv", vid_datavalid, 0);
        chk("disable_h_sync", vid_h_sync, 1);
        chk("disable_v_sync", vid_v_sync, 1);
        cyc(1);
        chk("disable_pixels_out", dv_count - d0, 2);
        expq.delete();
        enable = 1'b1;
        d0 = dv_count;
        send_frame(12, 1'b0);
        wait_drain("reenable_drain", 400);
        chk("reenable_dv_count", dv_count - d0, 12);

        // Asynchronous reset in the middle of an active line.
        d0 = dv_count;
        send_frame(12, 1'b0);
        wait_dv("run_before_reset", d0 + 3, 400);
        chk("dv_before_reset", vid_datavalid, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        expq.delete();
        cyc(2);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("in_ready_after_reset", in_ready, 0);
        cyc(1);
        chk("in_ready_restored", in_ready, 1);
        d0 = dv_count;
        send_frame(12, 1'b1);
        wait_drain("post_reset_drain", 400);
        chk("post_reset_dv_count", dv_count - d0, 12);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
